timer_countdown: RTL and testbench

- BCD countdown timer that consumes the MM:SS value produced by the timer-input stage and counts it down to 00:00 while cooking is active.
- It is the reader/consumer end of the timer-input interface. TimerInput writes the digits and pulses load; this block latches them, runs, pauses and signals completion to the control FSM and the display.
- Max value 99:59.

---
 rtl/timer_countdown.sv | 158 +++++++++++++++
 tb/tb_timer_countdown.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/timer_countdown.sv
// BCD MM:SS countdown timer. Latches digits from the timer-input stage on
// load, counts down one second per TICKS_PER_SEC clocks while running, and
// flags completion (done) and rejected loads (err) with one-cycle pulses.
module timer_countdown #(
    parameter int TICKS_PER_SEC = 100,
    parameter int PW            = 7
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic       cancel,
    input  logic [3:0] min_t,
    input  logic [3:0] min_o,
    input  logic [3:0] sec_t,
    input  logic [3:0] sec_o,
    output logic [3:0] q_min_t,
    output logic [3:0] q_min_o,
    output logic [3:0] q_sec_t,
    output logic [3:0] q_sec_o,
    output logic       running,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;      // {min_t, min_o, sec_t, sec_o}
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, done_q, done_d, err_q, err_d;

    logic [15:0]   din_s;
    logic [15:0]   cnt_dec_s;
    logic          load_ok_s;

    // A digit set is legal only if every digit is decimal and sec_t <= 5.
    function automatic logic digits_valid(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        if ((v[15:12] > 4'd9) || (v[11:8] > 4'd9) ||
            (v[7:4] > 4'd5) || (v[3:0] > 4'd9)) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    // One-second BCD decrement with borrow across sec_o, sec_t, min_o, min_t.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] mt, mo, st, so;
        mt = v[15:12];
        mo = v[11:8];
        st = v[7:4];
        so = v[3:0];
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign din_s     = {min_t, min_o, sec_t, sec_o};
    assign cnt_dec_s = bcd_dec(cnt_q);
    assign load_ok_s = (state_q == ST_IDLE) || (state_q == ST_ARMED) ||
                       (state_q == ST_DONE);

    // Next-state logic: cancel > load > pause > start, then prescaler/decrement in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (cancel) begin
            state_d = ST_IDLE;
            cnt_d   = 16'h0000;
            presc_d = '0;
        end else if (load && load_ok_s) begin
            if (digits_valid(din_s)) begin
                cnt_d   = din_s;
                presc_d = '0;
                state_d = (din_s != 16'h0000) ? ST_ARMED : ST_IDLE;
            end else begin
                err_d = 1'b1;
            end
        end else if (pause && (state_q == ST_RUN)) begin
            state_d = ST_HOLD;
        end else if (start && ((state_q == ST_ARMED) || (state_q == ST_HOLD))) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                cnt_d   = cnt_dec_s;
                if (cnt_dec_s == 16'h0000) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, count, prescaler and output registers; clr clears everything at once.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'h0000;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign q_min_t = cnt_q[15:12];
    assign q_min_o = cnt_q[11:8];
    assign q_sec_t = cnt_q[7:4];
    assign q_sec_o = cnt_q[3:0];
    assign running = running_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_timer_countdown.sv
// Directed bench for timer_countdown with TICKS_PER_SEC=4: a vector table for
// the single-cycle behaviour plus hand sequences for pause/resume and clr.
module tb_timer_countdown;

    logic       clk = 1'b0;
    logic       clr, load, start, pause, cancel;
    logic [3:0] min_t, min_o, sec_t, sec_o;
    logic [3:0] q_min_t, q_min_o, q_sec_t, q_sec_o;
    logic       running, done, err;

    int checks   = 0;
    int failures = 0;

    timer_countdown #(.TICKS_PER_SEC(4), .PW(7)) dut (
        .clk(clk), .clr(clr), .load(load), .start(start), .pause(pause),
        .cancel(cancel), .min_t(min_t), .min_o(min_o), .sec_t(sec_t),
        .sec_o(sec_o), .q_min_t(q_min_t), .q_min_o(q_min_o),
        .q_sec_t(q_sec_t), .q_sec_o(q_sec_o), .running(running),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld, st, pa, ca;
        logic [15:0] din;
        logic [15:0] eq;
        logic        er, ed, ee;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic ld, input logic st,
                                input logic pa, input logic ca, input logic [15:0] din,
                                input logic [15:0] eq, input logic er,
                                input logic ed, input logic ee);
        vec_t v;
        v.nm = nm; v.ld = ld; v.st = st; v.pa = pa; v.ca = ca;
        v.din = din; v.eq = eq; v.er = er; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] qv();
        return {q_min_t, q_min_o, q_sec_t, q_sec_o};
    endfunction

    task automatic check_all(input string nm, input logic [15:0] eq,
                             input logic er, input logic ed, input logic ee);
        check({nm, ".q"}, qv(), eq);
        check({nm, ".running"}, {15'd0, running}, {15'd0, er});
        check({nm, ".done"}, {15'd0, done}, {15'd0, ed});
        check({nm, ".err"}, {15'd0, err}, {15'd0, ee});
    endtask

    // Apply one cycle of pulses, then sample 1 time unit after the edge.
    task automatic cyc(input logic ld, input logic st, input logic pa,
                       input logic ca, input logic [15:0] din);
        load = ld; start = st; pause = pa; cancel = ca;
        {min_t, min_o, sec_t, sec_o} = din;
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; cancel = 1'b0;
    endtask

    initial begin
        clr = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; cancel = 1'b0;
        {min_t, min_o, sec_t, sec_o} = 16'h0000;

        // Basic countdown from 00:03 with ticks every 4 cycles.
        vecs.push_back(mk("ld0003", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("start",  1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0003, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("pre3", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("tick2", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("pre2", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("tick1", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("pre1", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("tick0",    1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("done_st",  1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("done_pa",  1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("cancel",   1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        // Invalid loads in IDLE.
        vecs.push_back(mk("bad0075",  1'b1, 1'b0, 1'b0, 1'b0, 16'h0075, 16'h0000, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("errfall",  1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("bad0A00",  1'b1, 1'b0, 1'b0, 1'b0, 16'h0A00, 16'h0000, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("bad000A",  1'b1, 1'b0, 1'b0, 1'b0, 16'h000A, 16'h0000, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("badst_ig", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        // Zero load stays IDLE; start is ignored.
        vecs.push_back(mk("ld0000",   1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("zero_st",  1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
        // Minute borrow 10:00 -> 09:59.
        vecs.push_back(mk("ld1000",   1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("bad_arm",  1'b1, 1'b0, 1'b0, 1'b0, 16'h0060, 16'h1000, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("st1000",   1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1000, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("pre1000", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1000, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("tick0959", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0959, 1'b1, 1'b0, 1'b0));
        // Cancel beats load in RUN.
        vecs.push_back(mk("cancld",   1'b1, 1'b0, 1'b0, 1'b1, 16'h0042, 16'h0000, 1'b0, 1'b0, 1'b0));
        // Borrow 01:00 -> 00:59, then load in RUN ignored.
        vecs.push_back(mk("ld0100",   1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("st0100",   1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0100, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("pre0100", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0100, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("tick0059", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0059, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("ldrun_ig", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h0059, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("badrun",   1'b1, 1'b0, 1'b0, 1'b0, 16'h00F0, 16'h0059, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("cancel2",  1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            cyc(vecs[i].ld, vecs[i].st, vecs[i].pa, vecs[i].ca, vecs[i].din);
            check_all(vecs[i].nm, vecs[i].eq, vecs[i].er, vecs[i].ed, vecs[i].ee);
        end

        // Pause after two prescaler steps, hold, then resume.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0005);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);   // RUN, prescaler 0
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);   // prescaler 1
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);   // prescaler 2
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);   // HOLD, prescaler stays 2
        check_all("pause", 16'h0005, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            check_all("hold", 16'h0005, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);   // RUN re-entry
        check_all("resume", 16'h0005, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_all("resume+1", 16'h0005, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_all("resume+2", 16'h0004, 1'b1, 1'b0, 1'b0);

        // Pause on the tick edge: no decrement, tick one cycle after resume.
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);   // prescaler 1,2,3
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        check_all("pause_tick", 16'h0004, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_all("resume_t", 16'h0004, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_all("resume_t+1", 16'h0003, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

        // Asynchronous clear mid-run at 00:02.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0003);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_all("pre_clr", 16'h0002, 1'b1, 1'b0, 1'b0);
        #2;
        clr = 1'b0;
        #1;
        check_all("async_clr", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            check_all("after_clr", 16'h0000, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
